// File: rtl/store_commit_unit.sv
// store_commit_unit
// Drains committed stores from the store-queue head to the data-memory write
// port, one store in flight at a time and strictly in program order. The head
// entry is fired over a valid/ready request. After the write acknowledge, the
// completion is reported back to the store queue by ROB tag.
module store_commit_unit #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 4,
  parameter int STQ_SIZE      = 8,
  parameter int STQ_TAG_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [STQ_TAG_WIDTH-1:0]            head,
  input  logic [STQ_SIZE-1:0]                 stq_valid,
  input  logic [STQ_SIZE-1:0]                 stq_address_valid,
  input  logic [STQ_SIZE-1:0]                 stq_data_valid,
  input  logic [STQ_SIZE-1:0]                 stq_committed,
  input  logic [STQ_SIZE-1:0]                 stq_executed,
  input  logic [STQ_SIZE-1:0]                 stq_succeeded,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]       stq_address,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]       stq_data,
  input  logic [STQ_SIZE-1:0][ROB_TAG_WIDTH-1:0] stq_rob_tag,
  output logic                                store_fired,
  output logic [$clog2(STQ_SIZE)-1:0]         store_fired_index,
  output logic                                store_succeeded,
  output logic [ROB_TAG_WIDTH-1:0]            store_succeeded_rob_tag,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic [XLEN-1:0]                     mem_req_addr,
  output logic [XLEN-1:0]                     mem_req_data,
  input  logic                                mem_resp_valid,
  output logic                                busy,
  output logic [31:0]                         stores_retired
);

  localparam int IDX_W = $clog2(STQ_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                     state_r;
  state_t                     state_s;
  logic                       fire_s;
  logic                       accept_s;
  logic                       ack_s;

  logic [IDX_W-1:0]           head_idx_s;
  logic                       head_wrap_unused_s;
  logic                       eligible_s;

  logic                       fired_r;
  logic [IDX_W-1:0]           fired_index_r;
  logic                       succeeded_r;
  logic [ROB_TAG_WIDTH-1:0]   succeeded_tag_r;
  logic                       req_valid_r;
  logic [XLEN-1:0]            req_addr_r;
  logic [XLEN-1:0]            req_data_r;
  logic [ROB_TAG_WIDTH-1:0]   tag_r;
  logic                       busy_r;
  logic [31:0]                retired_r;

  // Only the index bits select an entry; the wrap bit carries no meaning here.
  assign head_idx_s         = head[IDX_W-1:0];
  assign head_wrap_unused_s = ^head[STQ_TAG_WIDTH-1:IDX_W];

  // The head entry may be drained once it is committed, fully formed and not yet sent.
  assign eligible_s = stq_valid[head_idx_s] & stq_committed[head_idx_s] &
                      stq_address_valid[head_idx_s] & stq_data_valid[head_idx_s] &
                      ~stq_executed[head_idx_s] & ~stq_succeeded[head_idx_s];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode plus the fire/accept/ack strobes that drive the datapath.
  always_comb begin
    state_s  = state_r;
    fire_s   = 1'b0;
    accept_s = 1'b0;
    ack_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (eligible_s) begin
          state_s = S_REQ;
          fire_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (req_valid_r && mem_req_ready) begin
          state_s  = S_WAIT;
          accept_s = 1'b1;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          state_s = S_DONE;
          ack_s   = 1'b1;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Latch the head entry on fire and hold it stable for the whole request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_addr_r    <= {XLEN{1'b0}};
      req_data_r    <= {XLEN{1'b0}};
      tag_r         <= {ROB_TAG_WIDTH{1'b0}};
      fired_index_r <= {IDX_W{1'b0}};
    end else if (fire_s) begin
      req_addr_r    <= stq_address[head_idx_s];
      req_data_r    <= stq_data[head_idx_s];
      tag_r         <= stq_rob_tag[head_idx_s];
      fired_index_r <= head_idx_s;
    end else begin
      req_addr_r    <= req_addr_r;
      req_data_r    <= req_data_r;
      tag_r         <= tag_r;
      fired_index_r <= fired_index_r;
    end
  end

  // Request valid rises with the fire and drops once memory accepts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_valid_r <= 1'b0;
    end else if (fire_s) begin
      req_valid_r <= 1'b1;
    end else if (accept_s) begin
      req_valid_r <= 1'b0;
    end else begin
      req_valid_r <= req_valid_r;
    end
  end

  // One-cycle pulses back to the store queue; the tag holds between pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fired_r         <= 1'b0;
      succeeded_r     <= 1'b0;
      succeeded_tag_r <= {ROB_TAG_WIDTH{1'b0}};
    end else begin
      fired_r     <= fire_s;
      succeeded_r <= ack_s;
      if (ack_s) begin
        succeeded_tag_r <= tag_r;
      end else begin
        succeeded_tag_r <= succeeded_tag_r;
      end
    end
  end

  // Busy mirrors the state register; the retired count bumps on each acknowledge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_r    <= 1'b0;
      retired_r <= 32'd0;
    end else begin
      busy_r <= (state_s != S_IDLE);
      if (ack_s) begin
        retired_r <= retired_r + 32'd1;
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  assign store_fired             = fired_r;
  assign store_fired_index       = fired_index_r;
  assign store_succeeded         = succeeded_r;
  assign store_succeeded_rob_tag = succeeded_tag_r;
  assign mem_req_valid           = req_valid_r;
  assign mem_req_addr            = req_addr_r;
  assign mem_req_data            = req_data_r;
  assign busy                    = busy_r;
  assign stores_retired          = retired_r;

endmodule

// File: tb/tb_store_commit_unit.sv
// Scoreboard bench for store_commit_unit. The stimulus pushes the expected
// fire / accept / succeed events into a queue. A monitor pops the queue and
// checks each event as the DUT presents it. A small memory model drives the
// ready and acknowledge signals.
module tb_store_commit_unit;

  localparam int XLEN  = 32;
  localparam int RTW   = 4;
  localparam int SSZ   = 8;
  localparam int STW   = 4;
  localparam int IDX_W = 3;

  localparam int EV_FIRE = 0;
  localparam int EV_ACC  = 1;
  localparam int EV_SUCC = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [STW-1:0]             head;
  logic [SSZ-1:0]             stq_valid, stq_address_valid, stq_data_valid;
  logic [SSZ-1:0]             stq_committed, stq_executed, stq_succeeded;
  logic [SSZ-1:0][XLEN-1:0]   stq_address, stq_data;
  logic [SSZ-1:0][RTW-1:0]    stq_rob_tag;
  logic                       store_fired;
  logic [IDX_W-1:0]           store_fired_index;
  logic                       store_succeeded;
  logic [RTW-1:0]             store_succeeded_rob_tag;
  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic [XLEN-1:0]            mem_req_addr, mem_req_data;
  logic                       mem_resp_valid;
  logic                       busy;
  logic [31:0]                stores_retired;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  req_cycles = 0;

  // Memory model controls, written only by the stimulus process.
  bit  auto_resp  = 1'b1;
  bit  force_resp = 1'b0;
  int  stall_cfg  = 0;

  always #5 clk = ~clk;

  store_commit_unit #(
    .XLEN(XLEN), .ROB_TAG_WIDTH(RTW), .STQ_SIZE(SSZ), .STQ_TAG_WIDTH(STW)
  ) dut (
    .clk(clk), .reset(reset), .head(head),
    .stq_valid(stq_valid), .stq_address_valid(stq_address_valid),
    .stq_data_valid(stq_data_valid), .stq_committed(stq_committed),
    .stq_executed(stq_executed), .stq_succeeded(stq_succeeded),
    .stq_address(stq_address), .stq_data(stq_data), .stq_rob_tag(stq_rob_tag),
    .store_fired(store_fired), .store_fired_index(store_fired_index),
    .store_succeeded(store_succeeded), .store_succeeded_rob_tag(store_succeeded_rob_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .busy(busy), .stores_retired(stores_retired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  // Check that the oldest expected event matches the kind the DUT just presented.
  task automatic check_front(input string name, input int kind, input logic [31:0] a,
                             input logic [31:0] d, input bit pop);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event a=0x%0h d=0x%0h, required no event", name, a, d);
    end else if (exp_q[0].kind != kind) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: event kind %0d seen, required kind %0d", name, kind, exp_q[0].kind);
      if (pop) void'(exp_q.pop_front());
    end else begin
      check({name, "_a"}, a, exp_q[0].a);
      if (kind == EV_ACC) check({name, "_d"}, d, exp_q[0].d);
      if (pop) void'(exp_q.pop_front());
    end
  endtask

  // Memory model: stalls ready for stall_cfg cycles per request and acknowledges one cycle after accept.
  initial begin
    int  stall_cnt = 0;
    bit  resp_next = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      mem_resp_valid = (auto_resp & resp_next) | force_resp;
      resp_next = 1'b0;
      if (mem_req_valid === 1'b1) begin
        if (stall_cnt < stall_cfg) begin
          mem_req_ready = 1'b0;
          stall_cnt++;
        end else begin
          mem_req_ready = 1'b1;
          resp_next     = 1'b1;
          stall_cnt     = 0;
        end
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  // Monitor: compares every presented DUT event against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (store_fired === 1'b1)
        check_front("fire_index", EV_FIRE, 32'(store_fired_index), 32'd0, 1'b1);
      if (mem_req_valid === 1'b1) begin
        req_cycles++;
        check_front("req", EV_ACC, mem_req_addr, mem_req_data, mem_req_ready === 1'b1);
      end
      if (store_succeeded === 1'b1)
        check_front("succ_tag", EV_SUCC, 32'(store_succeeded_rob_tag), 32'd0, 1'b1);
    end
  end

  task automatic clear_stq();
    stq_valid = '0; stq_address_valid = '0; stq_data_valid = '0;
    stq_committed = '0; stq_executed = '0; stq_succeeded = '0;
    stq_address = '0; stq_data = '0; stq_rob_tag = '0;
  endtask

  task automatic set_entry(input int i, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] tag, input bit committed);
    stq_valid[i] = 1'b1; stq_address_valid[i] = 1'b1; stq_data_valid[i] = 1'b1;
    stq_committed[i] = committed; stq_executed[i] = 1'b0; stq_succeeded[i] = 1'b0;
    stq_address[i] = addr; stq_data[i] = data; stq_rob_tag[i] = tag;
  endtask

  task automatic do_reset(input bit randomize_inputs);
    @(negedge clk);
    reset = 1'b0;
    if (randomize_inputs) begin
      head = 4'($urandom);
      stq_valid = 8'($urandom); stq_address_valid = 8'($urandom);
      stq_data_valid = 8'($urandom); stq_committed = 8'($urandom);
      stq_executed = 8'($urandom); stq_succeeded = 8'($urandom);
      for (int i = 0; i < SSZ; i++) begin
        stq_address[i] = $urandom; stq_data[i] = $urandom; stq_rob_tag[i] = 4'($urandom);
      end
      force_resp = 1'($urandom);
    end
    repeat (2) @(negedge clk);
    check("rst_fired", 32'(store_fired), 32'd0);
    check("rst_fired_index", 32'(store_fired_index), 32'd0);
    check("rst_succeeded", 32'(store_succeeded), 32'd0);
    check("rst_succ_tag", 32'(store_succeeded_rob_tag), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_req_addr", mem_req_addr, 32'd0);
    check("rst_req_data", mem_req_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_retired", stores_retired, 32'd0);
    clear_stq();
    head = 4'd0; force_resp = 1'b0; stall_cfg = 0; auto_resp = 1'b1;
    reset = 1'b1;
  endtask

  // Wait for the succeeded pulse, then mark and retire the entry like the store queue does.
  task automatic wait_succ_and_retire(input int idx);
    bit seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (store_succeeded === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL succ_timeout: no store_succeeded for entry %0d, required one", idx);
    end
    stq_succeeded[idx] = 1'b1;
    @(negedge clk);
    stq_valid[idx] = 1'b0;
    stq_succeeded[idx] = 1'b0;
    head = head + 4'd1;
  endtask

  initial begin
    int rc0;
    bit seen;
    reset = 1'b1;
    head  = 4'd0;
    clear_stq();

    // Reset with random inputs.
    do_reset(1'b1);

    // Single store, no stall.
    do_reset(1'b0);
    head = 4'd2;
    set_entry(2, 32'h0000_1000, 32'hDEAD_BEEF, 4'd5, 1'b1);
    push_ev(EV_FIRE, 32'd2, 32'd0);
    push_ev(EV_ACC, 32'h0000_1000, 32'hDEAD_BEEF);
    push_ev(EV_SUCC, 32'd5, 32'd0);
    rc0 = req_cycles;
    wait_succ_and_retire(2);
    check("single_req_cycles", 32'(req_cycles - rc0), 32'd1);
    check("single_retired", stores_retired, 32'd1);
    check("single_busy_after", 32'(busy), 32'd0);

    // Same store with ready held low for four cycles.
    do_reset(1'b0);
    stall_cfg = 4;
    head = 4'd2;
    set_entry(2, 32'h0000_1000, 32'hDEAD_BEEF, 4'd5, 1'b1);
    push_ev(EV_FIRE, 32'd2, 32'd0);
    push_ev(EV_ACC, 32'h0000_1000, 32'hDEAD_BEEF);
    push_ev(EV_SUCC, 32'd5, 32'd0);
    rc0 = req_cycles;
    wait_succ_and_retire(2);
    stall_cfg = 0;
    check("stall_req_cycles", 32'(req_cycles - rc0), 32'd5);
    check("stall_retired", stores_retired, 32'd1);

    // Head valid but not committed for ten cycles.
    do_reset(1'b0);
    head = 4'd3;
    set_entry(3, 32'h0000_0ABC, 32'h1234_5678, 4'd9, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("uncommitted_idle", {30'd0, busy, mem_req_valid}, 32'd0);
    end
    push_ev(EV_FIRE, 32'd3, 32'd0);
    push_ev(EV_ACC, 32'h0000_0ABC, 32'h1234_5678);
    push_ev(EV_SUCC, 32'd9, 32'd0);
    stq_committed[3] = 1'b1;
    @(negedge clk);
    check("commit_req_valid", 32'(mem_req_valid), 32'd1);
    check("commit_fired", 32'(store_fired), 32'd1);
    wait_succ_and_retire(3);
    check("commit_retired", stores_retired, 32'd1);

    // Head wrap: entry 7 then entry 0 in order.
    do_reset(1'b0);
    head = 4'd7;
    set_entry(7, 32'h0000_2000, 32'h1111_1111, 4'd3, 1'b1);
    set_entry(0, 32'h0000_2004, 32'h2222_2222, 4'd4, 1'b1);
    push_ev(EV_FIRE, 32'd7, 32'd0);
    push_ev(EV_ACC, 32'h0000_2000, 32'h1111_1111);
    push_ev(EV_SUCC, 32'd3, 32'd0);
    push_ev(EV_FIRE, 32'd0, 32'd0);
    push_ev(EV_ACC, 32'h0000_2004, 32'h2222_2222);
    push_ev(EV_SUCC, 32'd4, 32'd0);
    wait_succ_and_retire(7);
    wait_succ_and_retire(0);
    check("wrap_retired", stores_retired, 32'd2);
    check("wrap_head", 32'(head), 32'd9);

    // Reset while waiting for the acknowledge, then a stray acknowledge.
    do_reset(1'b0);
    auto_resp = 1'b0;
    head = 4'd1;
    set_entry(1, 32'h0000_3000, 32'h3333_3333, 4'd6, 1'b1);
    push_ev(EV_FIRE, 32'd1, 32'd0);
    push_ev(EV_ACC, 32'h0000_3000, 32'h3333_3333);
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy === 1'b1 && mem_req_valid === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_wait", 32'(seen), 32'd1);
    reset = 1'b0;
    stq_valid[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    force_resp = 1'b1;
    @(negedge clk);
    force_resp = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_succeeded", 32'(store_succeeded), 32'd0);
    check("abort_retired", stores_retired, 32'd0);
    check("abort_req_valid", 32'(mem_req_valid), 32'd0);
    auto_resp = 1'b1;

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
